// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard controller:
// FSM states, forward selects and the state-priority helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DMISS  = 2'd1,
        IMISS  = 2'd2,
        MDWAIT = 2'd3
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    // D-miss outranks mul/div, which outranks I-miss
    function automatic hz_state_e pick_state(
        input logic dmiss,
        input logic md,
        input logic imiss
    );
        if (dmiss) begin
            return DMISS;
        end else if (md) begin
            return MDWAIT;
        end else if (imiss) begin
            return IMISS;
        end
        return RUN;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Hazard-unit bundle: pipeline status in, stage-register controls,
// forward selects and performance counters out.
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
);
    logic              ICacheMiss;
    logic              DCacheMiss;
    logic              MdBusyE;
    logic              BranchE;
    logic              JalrE;
    logic              JalD;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] RdM;
    logic [REG_AW-1:0] RdW;
    logic [1:0]        RegReadE;
    logic              MemToRegE;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              PerfClr;

    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              StallW;
    logic              FlushF;
    logic              FlushD;
    logic              FlushE;
    logic              FlushM;
    logic              FlushW;
    logic [1:0]        Forward1E;
    logic [1:0]        Forward2E;
    logic [1:0]        State;
    logic [PERF_W-1:0] StallCnt;
    logic [PERF_W-1:0] FlushCnt;
    logic [PERF_W-1:0] LoadUseCnt;

    modport master (
        output ICacheMiss, DCacheMiss, MdBusyE,
        output BranchE, JalrE, JalD,
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegReadE, MemToRegE, RegWriteM, RegWriteW,
        output PerfClr,
        input  StallF, StallD, StallE, StallM, StallW,
        input  FlushF, FlushD, FlushE, FlushM, FlushW,
        input  Forward1E, Forward2E, State,
        input  StallCnt, FlushCnt, LoadUseCnt
    );

    modport slave (
        input  ICacheMiss, DCacheMiss, MdBusyE,
        input  BranchE, JalrE, JalD,
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegReadE, MemToRegE, RegWriteM, RegWriteW,
        input  PerfClr,
        output StallF, StallD, StallE, StallM, StallW,
        output FlushF, FlushD, FlushE, FlushM, FlushW,
        output Forward1E, Forward2E, State,
        output StallCnt, FlushCnt, LoadUseCnt
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Multi-cycle hazard controller: stall/flush/forward for the 5-stage
// pipe, cache-miss and mul/div sequencing, wrong-path kill, counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
) (
    input  logic           CpuClk,
    input  logic           CpuRst,
    hazard_ctrl_mc_if.slave hz
);

    localparam logic [REG_AW-1:0] X0 = '0;

    hz_state_e state_q;
    hz_state_e state_d;
    hz_state_e cause_st;
    logic      kill_q;
    logic      kill_d;
    logic      kill_set;
    logic      kill_fire;
    logic      redirect;
    logic      lu_hit;
    logic      lu_take;
    logic [4:0] stall;
    logic [4:0] flush;

    function automatic logic [1:0] fwd_sel(
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w,
        input logic [REG_AW-1:0] rs,
        input logic              used
    );
        if (used && wr_m && (rd_m != X0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (used && wr_w && (rd_w != X0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign redirect = hz.BranchE | hz.JalrE | hz.JalD;
    assign lu_hit = hz.MemToRegE && (hz.RdE != X0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // a stalled branch in DMISS/MDWAIT cannot redirect, so no kill there
    assign kill_set = redirect && hz.ICacheMiss &&
                      ((state_q == RUN) || (state_q == IMISS));
    assign kill_fire = kill_q && !hz.ICacheMiss;

    assign cause_st = pick_state(hz.DCacheMiss, hz.MdBusyE, hz.ICacheMiss);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    state_d = cause_st;
            DMISS:  if (!hz.DCacheMiss) state_d = cause_st;
            IMISS:  if (!hz.ICacheMiss) state_d = cause_st;
            MDWAIT: if (!hz.MdBusyE)    state_d = cause_st;
        endcase
        if (CpuRst) begin
            state_d = RUN;
        end
    end

    always_comb begin
        kill_d = kill_q;
        if (kill_set) begin
            kill_d = 1'b1;
        end else if (kill_fire) begin
            kill_d = 1'b0;
        end
        if (CpuRst) begin
            kill_d = 1'b0;
        end
    end

    always_ff @(posedge CpuClk) begin
        if (CpuRst) begin
            state_q <= RUN;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // bit order {F,D,E,M,W}
    always_comb begin
        stall   = 5'b00000;
        flush   = 5'b00000;
        lu_take = 1'b0;
        if (CpuRst) begin
            flush = 5'b11111;
        end else if (hz.DCacheMiss) begin
            stall = 5'b11110;
            flush = 5'b00001;
        end else if (hz.MdBusyE) begin
            stall = 5'b11100;
            flush = 5'b00010;
        end else if (lu_hit) begin
            stall   = 5'b11000;
            flush   = 5'b00100;
            lu_take = 1'b1;
        end else if (hz.BranchE || hz.JalrE) begin
            flush = 5'b01100;
        end else if (hz.JalD) begin
            flush = 5'b01000;
        end else if (hz.ICacheMiss) begin
            stall = 5'b10000;
            flush = 5'b01000;
        end
        if (kill_fire) begin
            flush[3] = 1'b1;
        end
    end

    assign hz.StallF = stall[4];
    assign hz.StallD = stall[3];
    assign hz.StallE = stall[2];
    assign hz.StallM = stall[1];
    assign hz.StallW = stall[0];
    assign hz.FlushF = flush[4];
    assign hz.FlushD = flush[3];
    assign hz.FlushE = flush[2];
    assign hz.FlushM = flush[1];
    assign hz.FlushW = flush[0];

    assign hz.Forward1E = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW,
                                  hz.RdW, hz.Rs1E, hz.RegReadE[1]);
    assign hz.Forward2E = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW,
                                  hz.RdW, hz.Rs2E, hz.RegReadE[0]);

    assign hz.State = state_q;

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk_i (CpuClk),
        .rst_i (CpuRst),
        .inc_i (stall[4]),
        .clr_i (hz.PerfClr),
        .cnt_o (hz.StallCnt)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk_i (CpuClk),
        .rst_i (CpuRst),
        .inc_i (flush[3] | flush[2]),
        .clr_i (hz.PerfClr),
        .cnt_o (hz.FlushCnt)
    );

    sat_counter #(.W(PERF_W)) u_lu_cnt (
        .clk_i (CpuClk),
        .rst_i (CpuRst),
        .inc_i (lu_take),
        .clr_i (hz.PerfClr),
        .cnt_o (hz.LoadUseCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed scenarios plus random traffic,
// every cycle compared against a behavioural model.
module tb_hazard_ctrl_mc;
    import hazard_pkg::*;

    localparam int AW   = 5;
    localparam int PW   = 4;
    localparam int CMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_mc_if #(.REG_AW(AW), .PERF_W(PW)) hz ();

    hazard_ctrl_mc #(.REG_AW(AW), .PERF_W(PW)) dut (
        .CpuClk (clk),
        .CpuRst (rst),
        .hz     (hz)
    );

    int total = 0;
    int bad   = 0;

    int   m_st;
    bit   m_kill;
    int   c_st, c_fl, c_lu;
    logic [4:0] e_stall, e_flush;
    logic [1:0] e_f1, e_f2;
    bit   e_lu, e_fire;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(bit wm, int rdm, bit ww, int rdw,
                                       int rs, bit used);
        if (used && wm && rdm != 0 && rdm == rs) return 2'b10;
        if (used && ww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic idle();
        hz.ICacheMiss = 0; hz.DCacheMiss = 0; hz.MdBusyE = 0;
        hz.BranchE = 0; hz.JalrE = 0; hz.JalD = 0;
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
        hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.RegReadE = 0; hz.MemToRegE = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.PerfClr = 0;
    endtask

    // settle inputs, derive expectations from the rules, compare
    task automatic settle();
        bit lu;
        #1;
        e_stall = 0; e_flush = 0; e_lu = 0;
        lu = hz.MemToRegE && hz.RdE != 0 &&
             (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        if (rst) e_flush = 5'b11111;
        else if (hz.DCacheMiss) begin e_stall = 5'b11110; e_flush = 5'b00001; end
        else if (hz.MdBusyE) begin e_stall = 5'b11100; e_flush = 5'b00010; end
        else if (lu) begin e_stall = 5'b11000; e_flush = 5'b00100; e_lu = 1; end
        else if (hz.BranchE || hz.JalrE) e_flush = 5'b01100;
        else if (hz.JalD) e_flush = 5'b01000;
        else if (hz.ICacheMiss) begin e_stall = 5'b10000; e_flush = 5'b01000; end
        e_fire = m_kill && !hz.ICacheMiss;
        if (e_fire) e_flush[3] = 1'b1;
        e_f1 = fwd(hz.RegWriteM, int'(hz.RdM), hz.RegWriteW, int'(hz.RdW),
                   int'(hz.Rs1E), hz.RegReadE[1]);
        e_f2 = fwd(hz.RegWriteM, int'(hz.RdM), hz.RegWriteW, int'(hz.RdW),
                   int'(hz.Rs2E), hz.RegReadE[0]);
        check("stall", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}, e_stall);
        check("flush", {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW}, e_flush);
        check("fwd1", hz.Forward1E, e_f1);
        check("fwd2", hz.Forward2E, e_f2);
        check("state", hz.State, m_st);
        check("stallcnt", hz.StallCnt, c_st);
        check("flushcnt", hz.FlushCnt, c_fl);
        check("lucnt", hz.LoadUseCnt, c_lu);
    endtask

    // model update for the coming edge, then move to the next cycle
    task automatic adv();
        bit hold, redir;
        redir = hz.BranchE || hz.JalrE || hz.JalD;
        if (rst) begin
            m_st = RUN; m_kill = 0; c_st = 0; c_fl = 0; c_lu = 0;
        end else begin
            if (redir && hz.ICacheMiss && (m_st == RUN || m_st == IMISS))
                m_kill = 1;
            else if (e_fire)
                m_kill = 0;
            hold = (m_st == DMISS && hz.DCacheMiss) ||
                   (m_st == MDWAIT && hz.MdBusyE) ||
                   (m_st == IMISS && hz.ICacheMiss);
            if (!hold)
                m_st = hz.DCacheMiss ? DMISS : hz.MdBusyE ? MDWAIT :
                       hz.ICacheMiss ? IMISS : RUN;
            if (hz.PerfClr) begin
                c_st = 0; c_fl = 0; c_lu = 0;
            end else begin
                if (e_stall[4]) c_st = sat(c_st);
                if (e_flush[3] || e_flush[2]) c_fl = sat(c_fl);
                if (e_lu) c_lu = sat(c_lu);
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic rand_in();
        if (hz.DCacheMiss) hz.DCacheMiss = ($urandom_range(0, 2) != 0);
        else hz.DCacheMiss = ($urandom_range(0, 11) == 0);
        if (hz.MdBusyE) hz.MdBusyE = ($urandom_range(0, 3) != 0);
        else hz.MdBusyE = ($urandom_range(0, 9) == 0);
        if (hz.ICacheMiss) hz.ICacheMiss = ($urandom_range(0, 2) != 0);
        else hz.ICacheMiss = ($urandom_range(0, 5) == 0);
        hz.BranchE = ($urandom_range(0, 5) == 0);
        hz.JalrE = ($urandom_range(0, 9) == 0);
        hz.JalD = ($urandom_range(0, 5) == 0);
        hz.Rs1D = AW'($urandom_range(0, 7));
        hz.Rs2D = AW'($urandom_range(0, 7));
        hz.Rs1E = AW'($urandom_range(0, 7));
        hz.Rs2E = AW'($urandom_range(0, 7));
        hz.RdE = AW'($urandom_range(0, 7));
        hz.RdM = AW'($urandom_range(0, 7));
        hz.RdW = AW'($urandom_range(0, 7));
        hz.RegReadE = 2'($urandom_range(0, 3));
        hz.MemToRegE = ($urandom_range(0, 2) == 0);
        hz.RegWriteM = ($urandom_range(0, 1) == 0);
        hz.RegWriteW = ($urandom_range(0, 1) == 0);
        hz.PerfClr = ($urandom_range(0, 39) == 0);
        rst = ($urandom_range(0, 59) == 0);
    endtask

    initial begin
        idle();
        rst = 1;
        m_st = RUN; m_kill = 0; c_st = 0; c_fl = 0; c_lu = 0;
        repeat (2) @(negedge clk);
        settle();
        check("rst_state", hz.State, RUN);
        check("rst_flush", {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW}, 5'b11111);
        adv();
        rst = 0;

        // load-use then forward from W
        hz.MemToRegE = 1; hz.RdE = 5; hz.Rs1D = 5;
        settle();
        check("lu_stall", {hz.StallF, hz.StallD}, 2'b11);
        check("lu_flushE", hz.FlushE, 1);
        adv();
        idle();
        hz.RegWriteW = 1; hz.RdW = 5; hz.Rs1E = 5; hz.RegReadE = 2'b10;
        settle();
        check("lu_fwdW", hz.Forward1E, 2'b01);
        check("lu_count", hz.LoadUseCnt, 1);
        adv();

        // double forward: M wins, x0 never forwards
        idle();
        hz.RegWriteM = 1; hz.RegWriteW = 1; hz.RdM = 7; hz.RdW = 7;
        hz.Rs2E = 7; hz.RegReadE = 2'b01;
        settle();
        check("dfwd_m", hz.Forward2E, 2'b10);
        adv();
        hz.RdM = 0; hz.RdW = 0;
        settle();
        check("dfwd_x0", hz.Forward2E, 2'b00);
        adv();

        // D-miss with a branch held in EX
        idle();
        hz.PerfClr = 1;
        cyc();
        hz.PerfClr = 0;
        for (int k = 0; k < 4; k++) begin
            hz.DCacheMiss = 1; hz.BranchE = 1;
            settle();
            check("dm_stall", {hz.StallF, hz.StallD, hz.StallE, hz.StallM}, 4'b1111);
            check("dm_flushW", hz.FlushW, 1);
            if (k > 0) check("dm_state", hz.State, DMISS);
            adv();
        end
        hz.DCacheMiss = 0;
        settle();
        check("dm_branch", {hz.FlushD, hz.FlushE}, 2'b11);
        check("dm_stallcnt", hz.StallCnt, 4);
        adv();

        // I-miss with jal in its 2nd cycle kills the returned fetch
        idle();
        for (int k = 0; k < 3; k++) begin
            hz.ICacheMiss = 1; hz.JalD = (k == 1);
            cyc();
        end
        idle();
        settle();
        check("kill_flushD", hz.FlushD, 1);
        adv();
        settle();
        check("kill_clear", hz.FlushD, 0);
        adv();

        // mul/div chained straight into a D-miss
        for (int k = 0; k < 5; k++) begin
            hz.MdBusyE = 1;
            settle();
            check("md_flushM", hz.FlushM, 1);
            if (k > 0) check("md_state", hz.State, MDWAIT);
            adv();
        end
        hz.MdBusyE = 0; hz.DCacheMiss = 1;
        settle();
        check("chain_md", hz.State, MDWAIT);
        adv();
        settle();
        check("chain_dm", hz.State, DMISS);
        adv();
        idle();
        cyc();
        cyc();

        // counter saturation, clear-over-increment, reset mid IMISS
        hz.PerfClr = 1;
        cyc();
        hz.PerfClr = 0;
        hz.ICacheMiss = 1;
        repeat (20) cyc();
        hz.PerfClr = 1;
        settle();
        check("sat_15", hz.StallCnt, CMAX);
        check("sat_imiss", hz.State, IMISS);
        adv();
        hz.PerfClr = 0;
        settle();
        check("clr_zero", hz.StallCnt, 0);
        adv();
        rst = 1;
        settle();
        check("rst_stall", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}, 0);
        adv();
        rst = 0;
        settle();
        check("rst_run", hz.State, RUN);
        adv();

        idle();
        for (int n = 0; n < 3000; n++) begin
            rand_in();
            cyc();
        end
        rst = 0;
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
